// File: rtl/por_seq_pkg.sv
// Shared types and elaboration helpers for the power-on reset sequencer.
package por_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Width of the stage index: holds 0..n, never narrower than one bit.
  function automatic int idx_w(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int cnt_w(input int hold, input int gap, input int tmo);
    return $clog2(max3(hold, gap, tmo) + 1);
  endfunction

endpackage

// File: rtl/por_seq_counter.sv
// Saturating up-counter with synchronous clear and a bank of ">= threshold" compares.
module por_seq_counter
  import por_seq_pkg::*;
#(
  parameter int CNT_W = 7,
  parameter int N_CMP = 1
) (
  input  logic                        sysclk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        en,
  input  logic [N_CMP-1:0][CNT_W-1:0] thr,
  output logic [CNT_W-1:0]            cnt,
  output logic [N_CMP-1:0]            ge
);

  logic [CNT_W-1:0] cnt_reg = '0;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign cnt = cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_CMP; gi++) begin : g_cmp
      assign ge[gi] = (cnt_reg >= thr[gi]);
    end
  endgenerate

endmodule

// File: rtl/por_reset_sequencer.sv
// Power-on reset sequencer: asserts all channel resets, then releases them in index order.
// Optional ready-wait timeout is built when POR_SEQ_TIMEOUT_EN is defined.
module por_reset_sequencer
  import por_seq_pkg::*;
#(
  parameter int  N_CH           = 4,
  parameter int  HOLD_CYCLES    = 16,
  parameter int  GAP_CYCLES     = 8,
  parameter int  TIMEOUT_CYCLES = 64,
  localparam int IDX_W          = idx_w(N_CH)
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             soft_req,
  input  logic [N_CH-1:0]  ch_ready,
  output logic [N_CH-1:0]  rst_out,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] stage,
  output logic             timeout_err
);

  localparam int CNT_W   = cnt_w(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam int CMP_GAP = 0;
`ifdef POR_SEQ_TIMEOUT_EN
  localparam int N_CMP   = 2;
  localparam int CMP_TMO = 1;
  // Fire on the edge where cnt reaches TIMEOUT_CYCLES, never before the gap is met.
  localparam int TMO_THR = (TIMEOUT_CYCLES - 1 > GAP_CYCLES) ? TIMEOUT_CYCLES - 1 : GAP_CYCLES;
`else
  localparam int N_CMP   = 1;
`endif

  generate
    if (N_CH < 1) begin : g_bad_nch
      $error("por_reset_sequencer: N_CH must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("por_reset_sequencer: HOLD_CYCLES must be >= 1");
    end
`ifdef POR_SEQ_TIMEOUT_EN
    if (TIMEOUT_CYCLES < GAP_CYCLES) begin : g_bad_tmo
      $error("por_reset_sequencer: TIMEOUT_CYCLES must be >= GAP_CYCLES");
    end
`endif
  endgenerate

  state_t           state_reg   = ST_HOLD;
  state_t           state_next;
  logic [N_CH-1:0]  rst_out_reg = '1;
  logic [N_CH-1:0]  rst_out_next;
  logic             busy_reg    = 1'b1;
  logic             busy_next;
  logic             done_reg    = 1'b0;
  logic             done_next;
  logic [IDX_W-1:0] stage_reg   = '0;
  logic [IDX_W-1:0] stage_next;

  logic                        cnt_clr;
  logic                        cnt_en;
  logic [CNT_W-1:0]            cnt;
  logic [N_CMP-1:0][CNT_W-1:0] thr;
  logic [N_CMP-1:0]            ge;
  logic                        hold_end;
  logic                        ready_sel;
  logic                        last_stage;
  logic                        release_now;
  logic [N_CH-1:0]             sel_ready;
  logic [N_CH-1:0]             rel_mask;

  assign thr[CMP_GAP] = CNT_W'(GAP_CYCLES);
`ifdef POR_SEQ_TIMEOUT_EN
  assign thr[CMP_TMO] = CNT_W'(TMO_THR);
`endif

  por_seq_counter #(
    .CNT_W (CNT_W),
    .N_CMP (N_CMP)
  ) u_counter (
    .sysclk (sysclk),
    .reset  (reset),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .thr    (thr),
    .cnt    (cnt),
    .ge     (ge)
  );

  assign hold_end = (cnt == CNT_W'(HOLD_CYCLES - 1));

  // Only the channel currently waited on may release the next one.
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign sel_ready[gi] = ch_ready[gi] && (stage_reg == IDX_W'(gi));
      if (gi == 0) begin : g_first
        assign rel_mask[gi] = 1'b0;
      end else begin : g_next
        assign rel_mask[gi] = (stage_reg == IDX_W'(gi - 1));
      end
    end
  endgenerate

  assign ready_sel  = |sel_ready;
  assign last_stage = (stage_reg == IDX_W'(N_CH - 1));

`ifdef POR_SEQ_TIMEOUT_EN
  logic err_reg = 1'b0;
  logic err_next;
  logic tmo_hit;

  assign tmo_hit     = (state_reg == ST_WAIT) && !ready_sel && ge[CMP_TMO];
  assign release_now = (ready_sel && ge[CMP_GAP]) || tmo_hit;
  assign err_next    = err_reg || tmo_hit;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_next;
    end
  end

  assign timeout_err = err_reg;
`else
  assign release_now = ready_sel && ge[CMP_GAP];
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    rst_out_next = rst_out_reg;
    busy_next    = busy_reg;
    done_next    = done_reg;
    stage_next   = stage_reg;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    case (state_reg)
      ST_HOLD: begin
        cnt_en = 1'b1;
        if (hold_end) begin
          rst_out_next[0] = 1'b0;
          stage_next      = '0;
          cnt_clr         = 1'b1;
          state_next      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_en = 1'b1;
        if (release_now) begin
          if (last_stage) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
            busy_next  = 1'b0;
          end else begin
            rst_out_next = rst_out_reg & ~rel_mask;
            stage_next   = stage_reg + IDX_W'(1);
            cnt_clr      = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (soft_req) begin
          rst_out_next = '1;
          done_next    = 1'b0;
          busy_next    = 1'b1;
          cnt_clr      = 1'b1;
          state_next   = ST_HOLD;
        end
      end
      default: begin
        state_next = ST_HOLD;
        cnt_clr    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_reg   <= ST_HOLD;
      rst_out_reg <= '1;
      busy_reg    <= 1'b1;
      done_reg    <= 1'b0;
      stage_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      rst_out_reg <= rst_out_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      stage_reg   <= stage_next;
    end
  end

  assign rst_out = rst_out_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign stage   = stage_reg;

endmodule

// File: tb/tb_por_reset_sequencer.sv
// Directed bench for por_reset_sequencer at default parameters (N_CH=4, HOLD=16, GAP=8, TIMEOUT=64).
module tb_por_reset_sequencer;

  logic       sysclk = 1'b0;
  logic       reset = 1'b0;
  logic       soft_req = 1'b0;
  logic [3:0] ch_ready = 4'b1111;
  logic [3:0] rst_out;
  logic       busy;
  logic       done;
  logic [2:0] stage;
  logic       timeout_err;

  int errors = 0;
  int checks = 0;

`ifdef POR_SEQ_TIMEOUT_EN
  localparam int RDY1_EDGE = 80;
`else
  localparam int RDY1_EDGE = 100;
`endif

  por_reset_sequencer dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .soft_req    (soft_req),
    .ch_ready    (ch_ready),
    .rst_out     (rst_out),
    .busy        (busy),
    .done        (done),
    .stage       (stage),
    .timeout_err (timeout_err)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".rst_out"}, 32'(rst_out), 32'hF);
    check({tag, ".busy"}, 32'(busy), 32'h1);
    check({tag, ".done"}, 32'(done), 32'h0);
    check({tag, ".stage"}, 32'(stage), 32'h0);
    check({tag, ".err"}, 32'(timeout_err), 32'h0);
  endtask

  // Edge e counts from the last edge that started the sequence (reset, soft_req or power-up).
  // Releases: bit0@16, bit1@25, bit2@t2, bit3@t2+9, done@t2+18.
  task automatic check_seq(input string tag, input int t2, input int hold_stage,
                           input int n_edges, input int rdy1_edge, input int soft_edge);
    logic [3:0] exp_rst;
    logic       exp_done;
    int         exp_stage;
    for (int e = 1; e <= n_edges; e++) begin
      tick();
      exp_rst[0] = !(e >= 16);
      exp_rst[1] = !(e >= 25);
      exp_rst[2] = !(e >= t2);
      exp_rst[3] = !(e >= t2 + 9);
      exp_done   = (e >= t2 + 18);
      if (e < 16)          exp_stage = hold_stage;
      else if (e < 25)     exp_stage = 0;
      else if (e < t2)     exp_stage = 1;
      else if (e < t2 + 9) exp_stage = 2;
      else                 exp_stage = 3;
      check($sformatf("%s.e%0d.rst_out", tag, e), 32'(rst_out), 32'(exp_rst));
      check($sformatf("%s.e%0d.done", tag, e), 32'(done), 32'(exp_done));
      check($sformatf("%s.e%0d.busy", tag, e), 32'(busy), 32'(!exp_done));
      check($sformatf("%s.e%0d.stage", tag, e), 32'(stage), 32'(exp_stage));
      check($sformatf("%s.e%0d.err", tag, e), 32'(timeout_err), 32'h0);
      if (rdy1_edge != 0 && e == rdy1_edge - 1) ch_ready[1] = 1'b1;
      if (soft_edge != 0 && e == soft_edge - 1) soft_req = 1'b1;
      if (soft_edge != 0 && e == soft_edge)     soft_req = 1'b0;
    end
    $display("seq %s: %0d edges checked, errors so far %0d", tag, n_edges, errors);
  endtask

  task automatic pulse_reset(input int cycles, input string tag);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      tick();
      check_reset_values($sformatf("%s.r%0d", tag, i));
    end
    reset = 1'b0;
    $display("reset %s: %0d cycles", tag, cycles);
  endtask

  initial begin
    logic [3:0] exp_rst;
    #1;
    check_reset_values("powerup");

    check_seq("powerup", 34, 0, 55, 0, 0);

    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    check("soft.rst_out", 32'(rst_out), 32'hF);
    check("soft.busy", 32'(busy), 32'h1);
    check("soft.done", 32'(done), 32'h0);
    $display("soft_req in DONE applied");
    check_seq("soft", 34, 3, 55, 0, 0);

    pulse_reset(1, "pre_rdy1");
    ch_ready[1] = 1'b0;
    check_seq("rdy1_late", RDY1_EDGE, 0, RDY1_EDGE + 20, RDY1_EDGE, 0);

    pulse_reset(1, "pre_softwait");
    check_seq("soft_in_wait", 34, 0, 55, 0, 36);

    pulse_reset(1, "pre_midreset");
    check_seq("mid_a", 34, 0, 38, 0, 0);
    pulse_reset(3, "mid");
    check_seq("mid_b", 34, 0, 55, 0, 0);

    pulse_reset(1, "pre_tmo");
    ch_ready[0] = 1'b0;
    for (int e = 1; e <= 88; e++) begin
      tick();
      exp_rst = 4'b1111;
      exp_rst[0] = !(e >= 16);
`ifdef POR_SEQ_TIMEOUT_EN
      exp_rst[1] = !(e >= 80);
      check($sformatf("tmo.e%0d.err", e), 32'(timeout_err), 32'(e >= 80));
`else
      check($sformatf("tmo.e%0d.err", e), 32'(timeout_err), 32'h0);
`endif
      check($sformatf("tmo.e%0d.rst_out", e), 32'(rst_out), 32'(exp_rst));
    end
    $display("timeout scenario checked, errors so far %0d", errors);
    pulse_reset(1, "post_tmo");
    ch_ready[0] = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
